// File: rtl/imem_boot_if.sv
// Pad-side load/request bus and i_mem write / CPU enable outputs of the tinysoc
// boot controller, bundled so the controller and its environment share one definition.
interface imem_boot_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int HALF_WIDTH = 6
);
  logic [HALF_WIDTH-1:0]   load_data;
  logic                    load_valid;
  logic                    run_req;
  logic                    step_req;
  logic                    halt_req;
  logic                    reload_req;
  logic [ADDR_WIDTH-1:0]   imem_waddr;
  logic [2*HALF_WIDTH-1:0] imem_wdata;
  logic                    imem_wr;
  logic                    cpu_en;
  logic                    loaded;
  logic [1:0]              state;

  modport master (
    output load_data, load_valid, run_req, step_req, halt_req, reload_req,
    input  imem_waddr, imem_wdata, imem_wr, cpu_en, loaded, state
  );

  modport slave (
    input  load_data, load_valid, run_req, step_req, halt_req, reload_req,
    output imem_waddr, imem_wdata, imem_wr, cpu_en, loaded, state
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot and run-control sequencer: packs half-words into i_mem at ascending
// addresses, then gates the CPU enable with run / single-step / halt / reload.
module imem_boot_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int HALF_WIDTH = 6
) (
  input  logic       clk,
  input  logic       rst,
  imem_boot_if.slave bus
);
  localparam logic [1:0] ST_LOAD   = 2'b00;
  localparam logic [1:0] ST_HALTED = 2'b01;
  localparam logic [1:0] ST_RUN    = 2'b10;
  localparam logic [1:0] ST_STEP   = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);

  logic [1:0]              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    half_q, half_d;
  logic [HALF_WIDTH-1:0]   hold_q, hold_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [2*HALF_WIDTH-1:0] wdata_q, wdata_d;
  logic                    loaded_q, loaded_d;

  // Next-state logic for the load sequencer and run-control FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    half_d   = half_q;
    hold_d   = hold_q;
    wr_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    loaded_d = loaded_q;
    case (state_q)
      ST_LOAD: begin
        if (bus.load_valid && !half_q) begin
          hold_d = bus.load_data;
          half_d = 1'b1;
        end else if (bus.load_valid) begin
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {bus.load_data, hold_q};
          half_d  = 1'b0;
          addr_d  = addr_q + ADDR_ONE;
          // The final word leaves LOAD; its write pulse lands in the first HALTED cycle.
          if (addr_q == ADDR_LAST) begin
            state_d  = ST_HALTED;
            loaded_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          half_d = half_q;
        end
      end
      ST_HALTED: begin
        if (bus.reload_req) begin
          state_d  = ST_LOAD;
          addr_d   = {ADDR_WIDTH{1'b0}};
          half_d   = 1'b0;
          loaded_d = 1'b0;
        end else if (bus.step_req) begin
          state_d = ST_STEP;
        end else if (bus.run_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        state_d = ST_HALTED;
      end
      ST_RUN: begin
        // Reload only stops the CPU here; a second reload in HALTED re-enters LOAD.
        if (bus.halt_req || bus.reload_req) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      half_q   <= 1'b0;
      hold_q   <= {HALF_WIDTH{1'b0}};
      wr_q     <= 1'b0;
      waddr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q  <= {(2*HALF_WIDTH){1'b0}};
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      half_q   <= half_d;
      hold_q   <= hold_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.imem_wr    = wr_q;
  assign bus.loaded     = loaded_q;
  assign bus.state      = state_q;
  assign bus.cpu_en     = (state_q == ST_RUN) || (state_q == ST_STEP);
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_imem_boot_ctrl;
  localparam logic [1:0] M_LOAD   = 2'd0;
  localparam logic [1:0] M_HALTED = 2'd1;
  localparam logic [1:0] M_RUN    = 2'd2;
  localparam logic [1:0] M_STEP   = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_boot_if #(.ADDR_WIDTH(3), .HALF_WIDTH(6)) bus ();

  imem_boot_ctrl #(.ADDR_WIDTH(3), .HALF_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        lv;
    logic [5:0]  d;
    logic        run;
    logic        step;
    logic        halt;
    logic        reload;
    logic [1:0]  e_state;
    logic        e_en;
    logic        e_wr;
    logic        e_loaded;
    logic [2:0]  e_waddr;
    logic [11:0] e_wdata;
  } vec_t;

  vec_t tbl[$];

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int wr_cnt   = 0;
  int wr_per_addr[8];
  logic [11:0] dut_mem[8];

  // Behavioural model: mode plus count of halves accepted in the current load.
  logic [1:0]  m_mode   = M_LOAD;
  int          m_halves = 0;
  logic [5:0]  m_lo     = 6'd0;
  logic        m_wr     = 1'b0;
  logic        m_loaded = 1'b0;
  logic [2:0]  m_waddr  = 3'd0;
  logic [11:0] m_wdata  = 12'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic lv, input logic [5:0] d,
                            input logic run, input logic step, input logic halt,
                            input logic reload);
    if (r) begin
      m_mode = M_LOAD; m_halves = 0; m_wr = 1'b0;
      m_waddr = 3'd0; m_wdata = 12'd0; m_loaded = 1'b0;
    end else begin
      m_wr = 1'b0;
      case (m_mode)
        M_LOAD: begin
          if (lv) begin
            if (m_halves % 2 == 0) begin
              m_lo = d;
            end else begin
              m_wr    = 1'b1;
              m_waddr = 3'(m_halves / 2);
              m_wdata = {d, m_lo};
            end
            m_halves++;
            if (m_halves == 16) begin
              m_mode = M_HALTED; m_loaded = 1'b1; m_halves = 0;
            end
          end
        end
        M_HALTED: begin
          if (reload) begin
            m_mode = M_LOAD; m_halves = 0; m_loaded = 1'b0;
          end else if (step) begin
            m_mode = M_STEP;
          end else if (run) begin
            m_mode = M_RUN;
          end
        end
        M_STEP: m_mode = M_HALTED;
        default: begin
          if (halt || reload) m_mode = M_HALTED;
        end
      endcase
    end
  endtask

  task automatic tick(input logic r, input logic lv, input logic [5:0] d,
                      input logic run, input logic step, input logic halt,
                      input logic reload);
    @(negedge clk);
    rst = r;
    bus.load_valid = lv;
    bus.load_data  = d;
    bus.run_req    = run;
    bus.step_req   = step;
    bus.halt_req   = halt;
    bus.reload_req = reload;
    model_step(r, lv, d, run, step, halt, reload);
    @(posedge clk);
    #1;
    if (bus.imem_wr === 1'b1) begin
      wr_cnt++;
      wr_per_addr[bus.imem_waddr]++;
      dut_mem[bus.imem_waddr] = bus.imem_wdata;
    end
    if (bus.cpu_en === 1'b1) en_cnt++;
    check("state",  32'(bus.state),      32'(m_mode));
    check("cpu_en", 32'(bus.cpu_en),     32'((m_mode == M_RUN) || (m_mode == M_STEP)));
    check("imem_wr", 32'(bus.imem_wr),   32'(m_wr));
    check("loaded", 32'(bus.loaded),     32'(m_loaded));
    check("waddr",  32'(bus.imem_waddr), 32'(m_waddr));
    check("wdata",  32'(bus.imem_wdata), 32'(m_wdata));
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_capture();
    wr_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      wr_per_addr[k] = 0;
      dut_mem[k] = 12'hFFF;
    end
  endtask

  // Load halves 1..16; stall_word >= 0 inserts three idle cycles before that word's high half.
  task automatic load_seq(input int stall_word);
    for (int j = 0; j < 16; j++) begin
      if (j == 2 * stall_word + 1) begin
        repeat (3) tick(1'b0, 1'b0, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      tick(1'b0, 1'b1, 6'(j + 1), 1'b0, 1'b0, 1'b0, 1'b0);
      if (j % 2 == 1) begin
        check("seq_wr", 32'(bus.imem_wr), 32'd1);
        check("seq_waddr", 32'(bus.imem_waddr), 32'(j / 2));
      end else begin
        check("seq_nowr", 32'(bus.imem_wr), 32'd0);
      end
    end
  endtask

  task automatic check_image(input string tag);
    logic [5:0] hi;
    logic [5:0] lo;
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd8);
    for (int k = 0; k < 8; k++) begin
      hi = 6'(2 * k + 2);
      lo = 6'(2 * k + 1);
      check($sformatf("%s_word%0d", tag, k), 32'(dut_mem[k]), 32'({hi, lo}));
      check($sformatf("%s_once%0d", tag, k), 32'(wr_per_addr[k]), 32'd1);
    end
    check({tag, "_state"}, 32'(bus.state), 32'(M_HALTED));
    check({tag, "_loaded"}, 32'(bus.loaded), 32'd1);
  endtask

  function automatic vec_t mk(input logic r, input logic lv, input logic [5:0] d,
                              input logic run, input logic step, input logic halt,
                              input logic reload, input logic [1:0] es, input logic een,
                              input logic ewr, input logic eld, input logic [2:0] ea,
                              input logic [11:0] ed);
    vec_t v;
    v.r = r; v.lv = lv; v.d = d; v.run = run; v.step = step; v.halt = halt;
    v.reload = reload; v.e_state = es; v.e_en = een; v.e_wr = ewr;
    v.e_loaded = eld; v.e_waddr = ea; v.e_wdata = ed;
    return v;
  endfunction

  initial begin
    logic [2:0]  pa;
    logic [11:0] pd;
    logic [5:0]  hi6;
    logic [5:0]  lo6;

    bus.load_valid = 1'b0; bus.load_data = 6'd0; bus.run_req = 1'b0;
    bus.step_req = 1'b0; bus.halt_req = 1'b0; bus.reload_req = 1'b0;

    // Directed table: reset, full load with a request-laden stall, then run control.
    tbl.push_back(mk(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                     M_LOAD, 1'b0, 1'b0, 1'b0, 3'd0, 12'd0));
    pa = 3'd0;
    pd = 12'd0;
    for (int i = 1; i <= 16; i++) begin
      if (i % 2 == 0) begin
        pa  = 3'(i / 2 - 1);
        hi6 = 6'(i);
        lo6 = 6'(i - 1);
        pd  = {hi6, lo6};
        tbl.push_back(mk(1'b0, 1'b1, 6'(i), 1'b0, 1'b0, 1'b0, 1'b0,
                         (i == 16) ? M_HALTED : M_LOAD, 1'b0, 1'b1, (i == 16), pa, pd));
      end else begin
        tbl.push_back(mk(1'b0, 1'b1, 6'(i), 1'b0, 1'b0, 1'b0, 1'b0,
                         M_LOAD, 1'b0, 1'b0, 1'b0, pa, pd));
      end
      if (i == 5) begin
        tbl.push_back(mk(1'b0, 1'b0, 6'h3F, 1'b1, 1'b1, 1'b1, 1'b1,
                         M_LOAD, 1'b0, 1'b0, 1'b0, pa, pd));
      end
    end
    tbl.push_back(mk(1'b0, 1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b0,
                     M_HALTED, 1'b0, 1'b0, 1'b1, pa, pd));
    tbl.push_back(mk(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                     M_HALTED, 1'b0, 1'b0, 1'b1, pa, pd));
    tbl.push_back(mk(1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b0,
                     M_STEP, 1'b1, 1'b0, 1'b1, pa, pd));
    tbl.push_back(mk(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                     M_HALTED, 1'b0, 1'b0, 1'b1, pa, pd));
    tbl.push_back(mk(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0,
                     M_STEP, 1'b1, 1'b0, 1'b1, pa, pd));
    tbl.push_back(mk(1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1,
                     M_HALTED, 1'b0, 1'b0, 1'b1, pa, pd));
    tbl.push_back(mk(1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 1'b1,
                     M_LOAD, 1'b0, 1'b0, 1'b0, pa, pd));

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].r, tbl[i].lv, tbl[i].d, tbl[i].run, tbl[i].step, tbl[i].halt, tbl[i].reload);
      check($sformatf("tbl%0d_state", i),  32'(bus.state),      32'(tbl[i].e_state));
      check($sformatf("tbl%0d_cpu_en", i), 32'(bus.cpu_en),     32'(tbl[i].e_en));
      check($sformatf("tbl%0d_wr", i),     32'(bus.imem_wr),    32'(tbl[i].e_wr));
      check($sformatf("tbl%0d_loaded", i), 32'(bus.loaded),     32'(tbl[i].e_loaded));
      check($sformatf("tbl%0d_waddr", i),  32'(bus.imem_waddr), 32'(tbl[i].e_waddr));
      check($sformatf("tbl%0d_wdata", i),  32'(bus.imem_wdata), 32'(tbl[i].e_wdata));
    end

    // Stalled load: three idle cycles between the halves of word 2.
    tick(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_capture();
    en_cnt = 0;
    load_seq(2);
    check_image("stall");
    check("load_en_cnt", 32'(en_cnt), 32'd0);

    // Run for the request edge plus five cycles, then halt.
    en_cnt = 0;
    tick(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) idle();
    tick(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("run_en_cnt", 32'(en_cnt), 32'd6);
    check("halt_en", 32'(bus.cpu_en), 32'd0);

    // Held run_req: halt still lasts one cycle before RUN resumes.
    tick(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("held_halt_state", 32'(bus.state), 32'(M_HALTED));
    tick(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("held_rerun_en", 32'(bus.cpu_en), 32'd1);

    // Reload from RUN needs two requests, then loading restarts at address 0.
    tick(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reload1_state", 32'(bus.state), 32'(M_HALTED));
    check("reload1_loaded", 32'(bus.loaded), 32'd1);
    tick(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reload2_state", 32'(bus.state), 32'(M_LOAD));
    check("reload2_loaded", 32'(bus.loaded), 32'd0);
    tick(1'b0, 1'b1, 6'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 6'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reload_wr", 32'(bus.imem_wr), 32'd1);
    check("reload_waddr", 32'(bus.imem_waddr), 32'd0);
    check("reload_wdata", 32'(bus.imem_wdata), 32'h891);

    // Reset after five halves restarts the load from word 0.
    repeat (3) tick(1'b0, 1'b1, 6'h15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_state", 32'(bus.state), 32'(M_LOAD));
    check("rst_wr", 32'(bus.imem_wr), 32'd0);
    clear_capture();
    load_seq(-1);
    check_image("after_rst");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      tick(($urandom_range(63) == 0), 1'($urandom_range(1)), 6'($urandom),
           ($urandom_range(5) == 0), ($urandom_range(7) == 0),
           ($urandom_range(7) == 0), ($urandom_range(9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
